// File: rtl/spi_shift_engine.sv
// SPI master shift engine (CPHA = 0, CPOL from config): one full-duplex transfer per start.
// Optional build macro SPI_LSB_FIRST_EN selects LSB-first bit order; default is MSB first.
module spi_shift_engine #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_L,
    input  logic                  data_select,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    input  logic                  read_start,
    input  logic                  serclk_polarity,
    input  logic [3:0]            serclk_speed,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  ss_n,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  collision
);

    localparam int unsigned EdgeW = $clog2(2 * DATA_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                  state_q, state_d;
    logic                    wr_act_q;
    logic                    sclk_q;
    logic [3:0]              speed_q;
    logic [3:0]              div_q;
    logic [EdgeW-1:0]        edge_q;
    logic [DATA_WIDTH-1:0]   tx_q;
    logic [DATA_WIDTH-1:0]   rx_sh_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;
    logic                    collision_q;

    logic                    wr_act;
    logic                    write_start;
    logic                    any_start;
    logic                    tick;
    logic                    last_edge;
    logic [DATA_WIDTH-1:0]   tx_word;
    logic [DATA_WIDTH-1:0]   tx_shifted;
    logic [DATA_WIDTH-1:0]   rx_shifted;

    assign wr_act      = ~(wr_L | data_select);
    assign write_start = wr_act & ~wr_act_q;
    assign any_start   = write_start | read_start;
    // Write beats a coincident read strobe.
    assign tx_word     = write_start ? bus_data_in : '1;
    assign tick        = (state_q == StShift) && (div_q == speed_q);
    assign last_edge   = tick && (edge_q == EdgeW'(2 * DATA_WIDTH - 1));

`ifdef SPI_LSB_FIRST_EN
    assign mosi       = tx_q[0];
    assign tx_shifted = {1'b1, tx_q[DATA_WIDTH-1:1]};
    assign rx_shifted = {miso, rx_sh_q[DATA_WIDTH-1:1]};
`else
    assign mosi       = tx_q[DATA_WIDTH-1];
    assign tx_shifted = {tx_q[DATA_WIDTH-2:0], 1'b1};
    assign rx_shifted = {rx_sh_q[DATA_WIDTH-2:0], miso};
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (any_start) state_d = StShift;
            StShift: if (last_edge) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_act_q    <= 1'b0;
            sclk_q      <= 1'b0;
            speed_q     <= '0;
            div_q       <= '0;
            edge_q      <= '0;
            tx_q        <= '1;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            collision_q <= 1'b0;
        end else begin
            wr_act_q <= wr_act;
            if (any_start && (state_q != StIdle)) collision_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    // sclk_q doubles as the latched CPOL once a transfer starts.
                    sclk_q <= serclk_polarity;
                    tx_q   <= '1;
                    if (any_start) begin
                        speed_q <= serclk_speed;
                        tx_q    <= tx_word;
                        div_q   <= '0;
                        edge_q  <= '0;
                    end
                end
                StShift: begin
                    if (tick) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + EdgeW'(1);
                        if (!edge_q[0]) rx_sh_q <= rx_shifted;
                        else            tx_q    <= tx_shifted;
                        if (last_edge) rx_data_q <= rx_sh_q;
                    end else begin
                        div_q <= div_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sclk      = sclk_q;
    assign ss_n      = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign rx_data   = rx_data_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: table vectors, random transfers against a cycle-count model,
// plus collision, mid-transfer reset, and held-strobe sequences.
module tb_spi_shift_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_L;
    logic       data_select;
    logic [7:0] bus_data_in;
    logic       read_start;
    logic       serclk_polarity;
    logic [3:0] serclk_speed;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       ss_n;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       collision;

    int checks = 0;
    int errors = 0;
    bit exp_coll = 1'b0;

    spi_shift_engine #(.DATA_WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_L            (wr_L),
        .data_select     (data_select),
        .bus_data_in     (bus_data_in),
        .read_start      (read_start),
        .serclk_polarity (serclk_polarity),
        .serclk_speed    (serclk_speed),
        .miso            (miso),
        .sclk            (sclk),
        .mosi            (mosi),
        .ss_n            (ss_n),
        .busy            (busy),
        .done            (done),
        .rx_data         (rx_data),
        .collision       (collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;    // 0 write, 1 read, 2 both strobes together
        logic [7:0] tx;
        logic [3:0] spd;
        bit         cpol;
        logic [7:0] rxw;     // word the slave returns on miso
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit j (0 = first on the wire) of a word in transfer order.
    function automatic logic bit_at(input logic [7:0] w, input int j);
`ifdef SPI_LSB_FIRST_EN
        return w[j];
`else
        return w[7-j];
`endif
    endfunction

    task automatic xfer(input string name, input int kind, input logic [7:0] tx,
                        input logic [3:0] spd, input bit cpol, input logic [7:0] rxw,
                        input logic [7:0] exp_rx, input int coll_at);
        int         half, tot, k, idx;
        logic [7:0] txw;
        logic       exp_mosi;
        serclk_polarity = cpol;
        serclk_speed    = spd;
        wr_L = 1'b1; data_select = 1'b1; read_start = 1'b0;
        @(posedge clk); #1;
        chk({name, " idle"}, {collision, sclk, mosi, ss_n, busy, done},
            {exp_coll, cpol, 1'b1, 1'b1, 1'b0, 1'b0});
        if (kind != 1) begin wr_L = 1'b0; data_select = 1'b0; bus_data_in = tx; end
        if (kind != 0) read_start = 1'b1;
        txw  = (kind == 1) ? 8'hFF : tx;
        half = int'(spd) + 1;
        tot  = 16 * half;
        for (int n = 0; n <= tot + 1; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                wr_L = 1'b1; data_select = 1'b1; read_start = 1'b0;
                serclk_speed    = 4'($urandom);
                serclk_polarity = 1'($urandom);
                bus_data_in     = 8'($urandom);
            end
            if (coll_at > 0 && n == coll_at - 1) begin wr_L = 1'b0; data_select = 1'b0; end
            if (coll_at > 0 && n == coll_at) begin
                wr_L = 1'b1; data_select = 1'b1; exp_coll = 1'b1;
            end
            k = n / half;
            if (k > 16) k = 16;
            idx = k / 2;
            exp_mosi = (idx < 8) ? bit_at(txw, idx) : 1'b1;
            chk($sformatf("%s n=%0d {coll,sclk,mosi,ss_n,busy,done}", name, n),
                {collision, sclk, mosi, ss_n, busy, done},
                {exp_coll, cpol ^ k[0], exp_mosi, n > tot, n <= tot, n == tot});
            if (n == tot) chk({name, " rx_data"}, rx_data, exp_rx);
            miso = (idx < 8) ? bit_at(rxw, idx) : 1'b0;
        end
    endtask

    initial begin
        int dones, rises;
        logic prev_busy;
        vecs[0] = '{0, 8'hA5, 4'd0,  1'b0, 8'hA5, 8'hA5};
        vecs[1] = '{1, 8'h00, 4'd3,  1'b1, 8'h3C, 8'h3C};
        vecs[2] = '{2, 8'h96, 4'd2,  1'b0, 8'hC3, 8'hC3};
        vecs[3] = '{0, 8'h01, 4'd1,  1'b1, 8'h01, 8'h01};
        vecs[4] = '{0, 8'hF0, 4'd15, 1'b0, 8'h0F, 8'h0F};
        vecs[5] = '{1, 8'h5A, 4'd0,  1'b1, 8'h00, 8'h00};

        reset = 1'b1; wr_L = 1'b1; data_select = 1'b1; read_start = 1'b0;
        bus_data_in = 8'h00; serclk_polarity = 1'b1; serclk_speed = 4'd0; miso = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset {sclk,mosi,ss_n,busy,done,coll}", {sclk, mosi, ss_n, busy, done, collision},
            6'b011000);
        chk("reset rx_data", rx_data, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            xfer($sformatf("vec%0d", i), vecs[i].kind, vecs[i].tx, vecs[i].spd, vecs[i].cpol,
                 vecs[i].rxw, vecs[i].exp_rx, 0);

        for (int i = 0; i < 16; i++) begin
            logic [7:0] w;
            w = 8'($urandom);
            xfer($sformatf("rand%0d", i), int'($urandom_range(0, 2)), 8'($urandom),
                 4'($urandom_range(0, 15)), 1'($urandom), w, w, 0);
        end

        // A write strobe data_select-high must not start anything.
        serclk_speed = 4'd0; serclk_polarity = 1'b0;
        wr_L = 1'b0; data_select = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no start without data_select", busy, 1'b0);
        wr_L = 1'b1;

        // Second write at T+5 is dropped and flags collision.
        xfer("coll", 0, 8'h11, 4'd0, 1'b0, 8'h11, 8'h11, 5);
        xfer("after coll", 1, 8'h00, 4'd0, 1'b0, 8'h6B, 8'h6B, 0);

        // Reset at T+7 of a speed=1 transfer.
        serclk_speed = 4'd1; serclk_polarity = 1'b0; miso = 1'b1;
        @(posedge clk); #1;
        wr_L = 1'b0; data_select = 1'b0; bus_data_in = 8'h22;
        @(posedge clk); #1;
        wr_L = 1'b1; data_select = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("busy before reset", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_coll = 1'b0;
        chk("midreset {sclk,mosi,ss_n,busy,done,coll}", {sclk, mosi, ss_n, busy, done, collision},
            6'b011000);
        chk("midreset rx_data", rx_data, 8'h00);
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            dones += int'(done);
        end
        chk("no done after midreset", dones, 0);

        // wr_L held low for 40 cycles yields exactly one transfer.
        serclk_speed = 4'd0; miso = 1'b1;
        wr_L = 1'b0; data_select = 1'b0; bus_data_in = 8'h5A;
        dones = 0; rises = 0; prev_busy = busy;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (c == 39) wr_L = 1'b1;
            dones += int'(done);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        data_select = 1'b1;
        chk("held wr_L done pulses", dones, 1);
        chk("held wr_L transfers", rises, 1);
        chk("held wr_L collision", collision, 1'b0);
        chk("held wr_L rx_data", rx_data, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
